// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared types, widths and byte-merge helper for the line buffer responder.
package line_buf_pkg;
    localparam int ADDR_W      = 32;
    localparam int BEAT_W      = 64;
    localparam int BURST_LEN   = 4;
    localparam int LINE_W      = BEAT_W * BURST_LEN;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_W       = ADDR_W - OFFSET_BITS;

    typedef enum logic [2:0] {IDLE, CHECK, WB, FILL, RESP} state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] mbe);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = mbe[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/burst_beat_counter.sv
// burst_beat_counter: 2-bit beat index for a 4-beat burst; wraps 3->0, clear has priority over increment.
module burst_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [1:0] beat_o,
    output logic       last_o
);
    logic [1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (inc_i) cnt_q <= cnt_q + 2'd1;
    end

    assign beat_o = cnt_q;
    assign last_o = cnt_q == 2'd3;
endmodule

// File: rtl/line_buffer_responder.sv
// line_buffer_responder: one-line write-back/write-allocate buffer between a CPU port and a burst memory port.
// Define LINE_BUF_STATS_EN to add saturating hit_count/miss_count outputs.
module line_buffer_responder
    import line_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_mbe,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_resp,
    output logic [31:0]       mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef LINE_BUF_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q;
    logic [TAG_W-1:0]  tag_q;
    logic              valid_q, dirty_q;
    logic [ADDR_W-1:2] addr_q;
    logic              we_q;
    logic [3:0]        mbe_q;
    logic [31:0]       wdata_q;
    logic [1:0]        beat;
    logic              last, beat_clr, beat_inc, hit;
    logic [TAG_W-1:0]  req_tag;
    logic [2:0]        word;

    assign req_tag = addr_q[ADDR_W-1:OFFSET_BITS];
    assign word    = addr_q[4:2];
    assign hit     = valid_q && tag_q == req_tag;

    burst_beat_counter u_beat (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (beat_clr),
        .inc_i  (beat_inc),
        .beat_o (beat),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_read || mem_write) state_d = CHECK;
            CHECK:   state_d = hit ? RESP : (dirty_q ? WB : FILL);
            WB:      if (pmem_resp && last) state_d = FILL;
            FILL:    if (pmem_resp && last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_resp   = state_q == RESP;
        pmem_write = state_q == WB;
        pmem_read  = state_q == FILL;
        mem_rdata  = (mem_resp && !we_q) ? line_q[{word, 5'b0} +: 32] : '0;
        pmem_addr  = pmem_write ? {tag_q, 5'b0} : (pmem_read ? {req_tag, 5'b0} : '0);
        pmem_wdata = pmem_write ? line_q[{beat, 6'b0} +: BEAT_W] : '0;
        beat_clr   = (state_d == WB || state_d == FILL) && state_d != state_q;
        beat_inc   = (pmem_write || pmem_read) && pmem_resp;
    end

    // The request is captured at acceptance so a dropped request still completes coherently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            mbe_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (mem_read || mem_write)) begin
                addr_q  <= mem_addr[ADDR_W-1:2];
                we_q    <= mem_write && !mem_read;
                mbe_q   <= mem_mbe;
                wdata_q <= mem_wdata;
            end
            if (state_q == WB && pmem_resp && last) dirty_q <= 1'b0;
            if (state_q == FILL && pmem_resp) begin
                line_q[{beat, 6'b0} +: BEAT_W] <= pmem_rdata;
                if (last) begin
                    valid_q <= 1'b1;
                    tag_q   <= req_tag;
                end
            end
            if (state_q == RESP && we_q) begin
                line_q[{word, 5'b0} +: 32] <= merge_bytes(line_q[{word, 5'b0} +: 32], wdata_q, mbe_q);
                dirty_q <= 1'b1;
            end
        end
    end

`ifdef LINE_BUF_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == CHECK) begin
            if (hit && hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
            if (!hit && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_line_buffer_responder.sv
// tb_line_buffer_responder: directed table, reset/drop corner cases and random traffic against a word-level memory model.
module tb_line_buffer_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_resp;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [31:0] pmem_addr;
    logic [63:0] pmem_wdata, pmem_rdata;
`ifdef LINE_BUF_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    line_buffer_responder dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_mbe    (mem_mbe),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
`ifdef LINE_BUF_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Power-on memory contents; line 0x100 holds the 0x1111../0x2222../0x3333../0x4444.. beats.
    function automatic bit [31:0] init_word(input int unsigned wa);
        int b;
        b = (wa & 7) >> 1;
        if ((wa >> 3) == 32'h8) return {8{4'(b + 1)}};
        return {wa[29:0], 2'b01} ^ 32'hC0DE0000;
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] m);
        bit [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    // Backing memory behind the burst port, keyed by word address.
    bit [31:0] mem[int unsigned];
    function automatic bit [31:0] mem_word(input int unsigned wa);
        return mem.exists(wa) ? mem[wa] : init_word(wa);
    endfunction

    int          rb_beat = 0;
    bit          rb_kind_wr = 0;
    bit          gap_en = 0;
    int          n_fill = 0, n_wb = 0;
    int unsigned rb_wa, wb_addr, fill_addr;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rb_beat   = 0;
                pmem_resp = 1'b0;
                continue;
            end
            if (pmem_resp) begin
                rb_beat++;
                if (rb_beat == 4) begin
                    rb_beat = 0;
                    if (rb_kind_wr) n_wb++;
                    else n_fill++;
                end
            end
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) check("pmem_exclusive", 64'(pmem_read && pmem_write), 64'd0);
            if ((pmem_read || pmem_write) && (!gap_en || $urandom_range(3) != 0)) begin
                rb_wa = (pmem_addr >> 2) + 32'(rb_beat * 2);
                if (rb_beat == 0) begin
                    check("pmem_align", 64'(pmem_addr[4:0]), 64'd0);
                    if (pmem_write) wb_addr = pmem_addr;
                    else fill_addr = pmem_addr;
                end
                rb_kind_wr = pmem_write;
                if (pmem_write) begin
                    mem[rb_wa]     = pmem_wdata[31:0];
                    mem[rb_wa + 1] = pmem_wdata[63:32];
                end else pmem_rdata = {mem_word(rb_wa + 1), mem_word(rb_wa)};
                pmem_resp = 1'b1;
            end
        end
    end

    // Architectural view: committed words, plus writes to the buffered line that a reset would lose.
    bit [31:0]   ref_w[int unsigned];
    bit [31:0]   pend[int unsigned];
    bit          m_valid = 0, m_dirty = 0;
    int unsigned m_line;

    function automatic bit [31:0] ref_read(input int unsigned wa);
        if (pend.exists(wa)) return pend[wa];
        if (ref_w.exists(wa)) return ref_w[wa];
        return init_word(wa);
    endfunction

    task automatic ref_txn(input bit rd, input bit wr, input bit [31:0] addr, input bit [3:0] mbe,
                           input bit [31:0] wdata, output bit [31:0] exp_rd, output int e_fill, output int e_wb);
        int unsigned wa, la;
        wa = addr >> 2;
        la = addr >> 5;
        e_fill = 0;
        e_wb = 0;
        exp_rd = 0;
        if (!(m_valid && m_line == la)) begin
            e_fill = 1;
            e_wb = m_dirty ? 1 : 0;
            foreach (pend[k]) ref_w[k] = pend[k];
            pend.delete();
            m_dirty = 0;
            m_valid = 1;
            m_line = la;
        end
        if (wr && !rd) begin
            pend[wa] = merge(ref_read(wa), wdata, mbe);
            m_dirty = 1;
        end else exp_rd = ref_read(wa);
    endtask

    task automatic do_req(input bit rd, input bit wr, input bit [31:0] addr, input bit [3:0] mbe,
                          input bit [31:0] wdata, output bit [31:0] rdata, output int lat, output bit ok);
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        mem_addr = addr;
        mem_mbe = mbe;
        mem_wdata = wdata;
        lat = 0;
        ok = 0;
        rdata = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            lat++;
            if (mem_resp) begin
                ok = 1;
                rdata = mem_rdata;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    typedef struct {
        bit        rd, wr;
        bit [31:0] addr;
        bit [3:0]  mbe;
        bit [31:0] wdata, exp_rdata;
        int        exp_lat, exp_fill, exp_wb;
    } vec_t;

    vec_t        tbl[10];
    bit [31:0]   rdata, exp_rd;
    int          lat, e_fill, e_wb, f0, w0;
    bit          ok, found;
    bit [31:0]   lines[5] = '{32'h100, 32'h200, 32'h300, 32'h1000, 32'hFFFF_FFE0};

    initial begin
        tbl[0] = '{1, 0, 32'h100, 4'h0, 32'h0, 32'h1111_1111, 6, 1, 0};
        tbl[1] = '{1, 0, 32'h104, 4'h0, 32'h0, 32'h1111_1111, 2, 0, 0};
        tbl[2] = '{0, 1, 32'h108, 4'b0011, 32'hDEAD_BEEF, 32'h0, 2, 0, 0};
        tbl[3] = '{1, 0, 32'h108, 4'h0, 32'h0, 32'h2222_BEEF, 2, 0, 0};
        tbl[4] = '{1, 1, 32'h10C, 4'hF, 32'hFFFF_FFFF, 32'h2222_2222, 2, 0, 0};
        tbl[5] = '{0, 1, 32'h110, 4'h0, 32'hFFFF_FFFF, 32'h0, 2, 0, 0};
        tbl[6] = '{1, 0, 32'h110, 4'h0, 32'h0, 32'h3333_3333, 2, 0, 0};
        tbl[7] = '{1, 0, 32'h11F, 4'h0, 32'h0, 32'h4444_4444, 2, 0, 0};
        tbl[8] = '{1, 0, 32'h200, 4'h0, 32'h0, 32'hC0DE_0201, 10, 1, 1};
        tbl[9] = '{1, 0, 32'h108, 4'h0, 32'h0, 32'h2222_BEEF, 6, 1, 0};

        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_mbe = '0;
        mem_addr = '0;
        mem_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_resp", 64'(mem_resp), 64'd0);
        check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
        check("rst_pmem_rw", 64'({pmem_read, pmem_write}), 64'd0);
        check("rst_pmem_addr", 64'(pmem_addr), 64'd0);
        check("rst_pmem_wdata", pmem_wdata, 64'd0);
        #2 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            f0 = n_fill;
            w0 = n_wb;
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].mbe, tbl[i].wdata, rdata, lat, ok);
            ref_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].mbe, tbl[i].wdata, exp_rd, e_fill, e_wb);
            check($sformatf("vec%0d_resp", i), 64'(ok), 64'd1);
            if (tbl[i].rd) check($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].exp_rdata));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            check($sformatf("vec%0d_fills", i), 64'(n_fill - f0), 64'(tbl[i].exp_fill));
            check($sformatf("vec%0d_writebacks", i), 64'(n_wb - w0), 64'(tbl[i].exp_wb));
        end
        check("wb_addr", 64'(wb_addr), 64'h100);
        check("wb_merged_word", 64'(mem_word(32'h42)), 64'h2222_BEEF);
        check("wb_mbe0_word", 64'(mem_word(32'h44)), 64'h3333_3333);
        check("fill_addr", 64'(fill_addr), 64'h100);

        // Reset in the second beat of a fill: port must drop at once and the next access refetches.
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 32'h200;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #2;
            found = pmem_read && rb_beat == 1;
        end
        check("rst_fill_sync", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_pmem_read", 64'(pmem_read), 64'd0);
        check("rst_mid_pmem_addr", 64'(pmem_addr), 64'd0);
        mem_read = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        pend.delete();
        m_valid = 0;
        m_dirty = 0;
        f0 = n_fill;
        w0 = n_wb;
        do_req(1, 0, 32'h200, 4'h0, 32'h0, rdata, lat, ok);
        ref_txn(1, 0, 32'h200, 4'h0, 32'h0, exp_rd, e_fill, e_wb);
        check("refetch_resp", 64'(ok), 64'd1);
        check("refetch_rdata", 64'(rdata), 64'hC0DE_0201);
        check("refetch_latency", 64'(lat), 64'd6);
        check("refetch_fills", 64'(n_fill - f0), 64'd1);
        check("refetch_writebacks", 64'(n_wb - w0), 64'd0);

        // Dirty the line, then drop a missing read after one cycle: write-back, fill and response all complete.
        do_req(0, 1, 32'h204, 4'hF, 32'hCAFE_F00D, rdata, lat, ok);
        ref_txn(0, 1, 32'h204, 4'hF, 32'hCAFE_F00D, exp_rd, e_fill, e_wb);
        check("drop_pre_write_resp", 64'(ok), 64'd1);
        f0 = n_fill;
        w0 = n_wb;
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 32'h30C;
        @(negedge clk);
        mem_read = 1'b0;
        mem_addr = 32'hFFFF_FFFC;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (mem_resp) begin
                ok = 1;
                rdata = mem_rdata;
            end
        end
        ref_txn(1, 0, 32'h30C, 4'h0, 32'h0, exp_rd, e_fill, e_wb);
        check("drop_resp", 64'(ok), 64'd1);
        check("drop_rdata", 64'(rdata), 64'(exp_rd));
        check("drop_fills", 64'(n_fill - f0), 64'(e_fill));
        check("drop_writebacks", 64'(n_wb - w0), 64'(e_wb));
        check("drop_wb_data", 64'(mem_word(32'h81)), 64'hCAFE_F00D);

        gap_en = 1;
        for (int i = 0; i < 300; i++) begin
            automatic int op = $urandom_range(9);
            automatic bit rd = op < 5 || op == 9;
            automatic bit wr = op >= 5;
            automatic bit [31:0] a = lines[$urandom_range(4)] | ($urandom & 32'h1F);
            automatic bit [3:0] m = 4'($urandom);
            automatic bit [31:0] wd = $urandom;
            repeat ($urandom_range(2)) @(negedge clk);
            f0 = n_fill;
            w0 = n_wb;
            do_req(rd, wr, a, m, wd, rdata, lat, ok);
            ref_txn(rd, wr, a, m, wd, exp_rd, e_fill, e_wb);
            check($sformatf("rnd%0d_resp", i), 64'(ok), 64'd1);
            if (rd) check($sformatf("rnd%0d_rdata@%h", i, a), 64'(rdata), 64'(exp_rd));
            check($sformatf("rnd%0d_fills", i), 64'(n_fill - f0), 64'(e_fill));
            check($sformatf("rnd%0d_writebacks", i), 64'(n_wb - w0), 64'(e_wb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
